// File: rtl/arb_pkg.sv
// Shared definitions for the grant arbiter.
// Contents:
//   arb_state_t          - arbiter FSM state (IDLE: nothing granted, GRANT: one owner)
//   ARB_NUM_REQ_DEFAULT  - default number of requesters
//   ARB_MAX_HOLD_DEFAULT - default maximum consecutive cycles a grant is held
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ_DEFAULT  = 4;
  localparam int ARB_MAX_HOLD_DEFAULT = 6;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search.
// Ports:
//   req_i    [NUM_REQ] - request levels, bit i is requester i
//   ptr_i    [PW]      - index of the last owner; the search starts at ptr_i+1
//   winner_o [PW]      - index of the first set request found from ptr_i+1 upward (wrapping)
//   valid_o            - high when any request bit is set
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [PW-1:0]      winner_o,
  output logic               valid_o
);

  // Walk offsets from farthest to nearest so the nearest set bit after
  // ptr_i is the last write and therefore wins. Offset NUM_REQ is ptr_i
  // itself, which keeps the old owner as the lowest-priority candidate.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      int idx;
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/gnt_arbiter.sv
// Round-robin grant arbiter with a bounded hold time.
// One requester owns the grant at a time. The owner keeps the grant while it
// requests, for at most MAX_HOLD consecutive cycles; at that limit the grant is
// forcibly released and preempt pulses for one cycle. Every release is followed
// by at least one idle cycle before the next arbitration.
// Ports:
//   clk         - clock, rising edge
//   reset_n     - asynchronous active-low reset
//   req[N]      - request levels, bit i is requester i
//   gnt[N]      - registered grant, one-hot or zero
//   busy        - high whenever any gnt bit is high
//   preempt     - one-cycle pulse after a forced release at MAX_HOLD
//   dbg_state_o - current FSM state, for observation
//
// Handshake: req[i] is a level. A grant is issued on the edge that samples the
// request while idle; the owner keeps it as long as req[owner] stays high and
// the hold limit is not reached. Dropping req[owner] releases the grant at the
// next edge.
module gnt_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ_DEFAULT,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               preempt,
  output arb_state_t         dbg_state_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               preempt_q;
  logic [PW-1:0]      ptr_q;
  logic [HW-1:0]      hold_q;

  logic [PW-1:0]      pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] win_onehot_d;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    win_onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  end

  // In GRANT, ptr_q is the owner index. Releasing on req[owner]=0 is checked
  // before the hold limit so a drop coinciding with the limit is a normal
  // release without preempt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      preempt_q <= 1'b0;
      ptr_q     <= PTR_RESET;
      hold_q    <= '0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= GRANT;
            gnt_q   <= win_onehot_d;
            ptr_q   <= pick_idx;
            hold_q  <= HW'(1);
          end
        end
        GRANT: begin
          if (!req[ptr_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            hold_q  <= '0;
          end else if (hold_q == HOLD_MAX) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign busy        = |gnt_q;
  assign preempt     = preempt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gnt_arbiter.sv
// Directed bench for gnt_arbiter (NUM_REQ=4, MAX_HOLD=6).
// Stimulus tasks push the expected {gnt, busy, preempt, state} seen after the
// next rising edge; a monitor pops and compares one entry per cycle. A second
// process checks grant safety properties every cycle.
module tb_gnt_arbiter;
  import arb_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int MAX_HOLD = 6;
  localparam int W        = NUM_REQ + 3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               preempt;
  arb_state_t         dbg_state;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gnt_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .gnt         (gnt),
    .busy        (busy),
    .preempt     (preempt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply req at the falling edge; expectation is for after the next rising edge.
  task automatic drive(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] eg, input logic ep);
    @(negedge clk);
    req = r;
    exp_q.push_back({eg, |eg, ep, |eg});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_preempt", preempt, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : monitor
    logic [W-1:0] e;
    #1;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if ({gnt, busy, preempt, dbg_state} !== e) begin
        mismatched++;
        $display("FAIL scoreboard: got gnt=%b busy=%b preempt=%b state=%b expected gnt=%b busy=%b preempt=%b state=%b",
                 gnt, busy, preempt, dbg_state, e[W-1:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- per-cycle safety checks ----------------
  int                 run_len = 0;
  logic [NUM_REQ-1:0] prev_gnt = '0;
  always @(posedge clk) begin : safety
    #1;
    if (!reset_n) begin
      run_len  = 0;
      prev_gnt = '0;
    end else begin
      run_len = busy ? run_len + 1 : 0;
      compared++;
      if (!$onehot0(gnt) || (busy !== (|gnt)) || (run_len > MAX_HOLD) ||
          (prev_gnt != 0 && gnt != 0 && gnt != prev_gnt)) begin
        mismatched++;
        $display("FAIL safety: gnt=%b prev_gnt=%b busy=%b run_len=%0d limit=%0d",
                 gnt, prev_gnt, busy, run_len, MAX_HOLD);
      end
      prev_gnt = gnt;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NUM_REQ-1:0] g;

    // Power-on reset values, checked while reset is asserted.
    #1;
    check("por_gnt", gnt, 0);
    check("por_busy", busy, 0);
    check("por_preempt", preempt, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Scenario 1: short request from requester 0.
    drive(4'b0000, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Scenario 2: all requesting, grants rotate 0,1,2,3,0 with preempt.
    do_reset();
    for (int o = 0; o < 5; o++) begin
      g = 4'b0001;
      g = g << (o % 4);
      for (int c = 0; c < MAX_HOLD; c++) drive(4'b1111, g, 1'b0);
      drive(4'b1111, 4'b0000, 1'b1);
    end
    drive(4'b0000, 4'b0000, 1'b0);

    // Scenario 3: lone requester 2 held for 20 cycles.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if ((k % 7) < 6) drive(4'b0100, 4'b0100, 1'b0);
      else             drive(4'b0100, 4'b0000, 1'b1);
    end
    // Drop lands exactly on the hold limit: plain release.
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Scenario 4: req[0] drops on the edge where the hold limit is reached.
    do_reset();
    for (int c = 0; c < MAX_HOLD; c++) drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Scenario 5: asynchronous reset in the middle of a grant.
    do_reset();
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0001, 4'b0001, 1'b0);
    drain();
    @(negedge clk);
    #2;
    check("pre_async_gnt", gnt, 4'b0001);
    reset_n = 1'b0;
    req     = '0;
    #1;
    check("async_gnt", gnt, 0);
    check("async_busy", busy, 0);
    check("async_preempt", preempt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // Scenario 6: owner 1 drops while requester 3 rises; non-owner ignored.
    do_reset();
    drive(4'b0010, 4'b0010, 1'b0);
    drive(4'b0011, 4'b0010, 1'b0);
    drive(4'b1000, 4'b0000, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gnt_arbiter.md
GNT_ARBITER -- requirements
Module: gnt_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_HOLD, default 6, giving the maximum consecutive cycles one grant is held (1..6).
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req  input  NUM_REQ  per-requester request level; bit i is requester i.
REQ-006 The block SHALL have port gnt  output  NUM_REQ  registered grant, one-hot or zero.
REQ-007 The block SHALL have port busy  output  1  high whenever any gnt bit is high.
REQ-008 The block SHALL have port preempt  output  1  one-cycle pulse marking a forced release at MAX_HOLD.

Function
REQ-009 The block SHALL implement a two-state FSM, IDLE and GRANT; gnt is zero in IDLE and one-hot in GRANT.
REQ-010 In IDLE with req nonzero at a clock edge, the FSM SHALL enter GRANT at that edge; the owner is the first set req bit searching from ptr+1 upward, wrapping modulo NUM_REQ.
REQ-011 Grant latency SHALL be one cycle: gnt[owner] rises on the edge that samples the request.
REQ-012 On entering GRANT, ptr SHALL load the owner index and hold_cnt SHALL load 1.
REQ-013 In GRANT, each edge with req[owner]=1 and hold_cnt<MAX_HOLD SHALL keep gnt unchanged and increment hold_cnt.
REQ-014 In GRANT, an edge with req[owner]=0 SHALL clear gnt and return the FSM to IDLE, with preempt staying low.
REQ-015 In GRANT, an edge with req[owner]=1 and hold_cnt==MAX_HOLD SHALL clear gnt, return the FSM to IDLE, and drive preempt high for exactly that next cycle.
REQ-016 After any release, gnt SHALL be zero for at least one cycle before the next grant, with no back-to-back grants.
REQ-017 Consequently, no gnt bit SHALL stay high for more than MAX_HOLD consecutive cycles, and busy SHALL never stay high for 7 or more consecutive cycles.
REQ-018 If req[owner] drops at the same edge where hold_cnt==MAX_HOLD, this SHALL be treated as a normal release (REQ-014) with no preempt.
REQ-019 Changes to non-owner req bits during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-020 A preempted owner that still requests SHALL be re-granted only after all other pending requesters, which follows from the ptr rotation in REQ-010.
REQ-021 hold_cnt SHALL be $clog2(MAX_HOLD+1) bits wide and SHALL never wrap.

Reset
REQ-022 On assertion of reset_n low, the block SHALL asynchronously set state=IDLE, gnt=0, busy=0, preempt=0, hold_cnt=0, and ptr=NUM_REQ-1, so that requester 0 has first priority.
REQ-023 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge, and SHALL not raise preempt.
REQ-024 The first arbitration after reset_n deasserts SHALL occur at the first clock edge that samples req nonzero.

Structure
REQ-025 The state enum arb_state_t {IDLE, GRANT} and the MAX_HOLD default constant SHALL live in the shared package arb_pkg.
REQ-026 The round-robin winner search SHALL be the combinational sub-module rr_pick (inputs req and ptr; outputs winner index and valid).
REQ-027 The bench SHALL bind an assertion checking REQ-017, REQ-016, and one-hot-or-zero gnt on every cycle.

Verification
REQ-028 Scenario 1: reset, then req=4'b0001 for 3 cycles then 0 -> gnt=0001 for 3 cycles starting one cycle after the request, then 0; preempt never rises.
REQ-029 Scenario 2: req=4'b1111 held constant -> grants rotate 0,1,2,3,0, each 6 cycles long with a 1-cycle gap, and preempt pulses at each release.
REQ-030 Scenario 3: req=4'b0100 held 20 cycles alone -> gnt=0100 for 6 cycles, gap, then 6 again, and so on; preempt pulses after each 6-cycle run.
REQ-031 Scenario 4: req[0] drops on the exact edge hold_cnt reaches 6 -> gnt clears and preempt stays 0.
REQ-032 Scenario 5: reset_n pulled low mid-grant between clock edges -> gnt and busy go 0 before the next edge; after release, req=4'b1000 yields gnt=1000.
REQ-033 Scenario 6: with gnt=0010 active, req[3] rises and req[1] falls in the same cycle -> gnt=0 for one cycle, then gnt=1000.
